// File: rtl/banner_msg_loader_pkg.sv
// Shared types and constants for the banner message loader.
package banner_msg_loader_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned COUNT_W      = 5;
  localparam int unsigned DEFAULT_N    = 10;
  localparam int unsigned MAX_N        = 16;
  localparam logic [3:0]  DEFAULT_FILL = 4'h0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_SWAP  = 2'd3
  } state_t;

  function automatic logic valid_n(input int unsigned n);
    return (n >= 1) && (n <= MAX_N);
  endfunction

endpackage

// File: rtl/banner_msg_loader_if.sv
// Digit write port plus published banner bus between the upstream source and the loader.
interface banner_msg_loader_if #(
  parameter int unsigned N = 10
);
  logic             wr_valid;
  logic             wr_ready;
  logic [3:0]       wr_data;
  logic             commit;
  logic             clear;
  logic [N*4-1:0]   data;
  logic [4:0]       count;
  logic             full;
  logic             busy;

  modport master (
    output wr_valid, wr_data, commit, clear,
    input  wr_ready, data, count, full, busy
  );

  modport slave (
    input  wr_valid, wr_data, commit, clear,
    output wr_ready, data, count, full, busy
  );
endinterface

// File: rtl/banner_shadow_buf.sv
// N x 4-bit shadow register array: indexed digit write, parallel clear to FILL, flat read.
module banner_shadow_buf
  import banner_msg_loader_pkg::*;
#(
  parameter int unsigned N    = DEFAULT_N,
  parameter logic [3:0]  FILL = DEFAULT_FILL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [COUNT_W-1:0]   wr_idx,
  input  logic [DIGIT_W-1:0]   wr_digit,
  input  logic                 clr,
  output logic [N*DIGIT_W-1:0] flat
);

  logic [DIGIT_W-1:0] mem [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N); i++) mem[i] <= FILL;
    end else if (clr) begin
      for (int i = 0; i < int'(N); i++) mem[i] <= FILL;
    end else if (wr_en) begin
      for (int i = 0; i < int'(N); i++) begin
        if (wr_idx == COUNT_W'(i)) mem[i] <= wr_digit;
      end
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < int'(N); i++) flat[i*DIGIT_W +: DIGIT_W] = mem[i];
  end

endmodule

// File: rtl/banner_msg_loader.sv
// Collects banner digits into a shadow buffer and publishes them atomically on commit.
// Optional macro BANNER_AUTOCOMMIT_EN: filling the last digit starts the swap by itself.
module banner_msg_loader
  import banner_msg_loader_pkg::*;
#(
  parameter int unsigned N    = DEFAULT_N,
  parameter logic [3:0]  FILL = DEFAULT_FILL
) (
  input  logic                clk,
  input  logic                reset,
  banner_msg_loader_if.slave  bus
);

  if (!valid_n(N)) begin : g_bad_n
    $error("banner_msg_loader: N must be in 1..16");
  end

  state_t                 state, state_n;
  logic [COUNT_W-1:0]     count, count_n;
  logic [N*DIGIT_W-1:0]   data_q;
  logic [N*DIGIT_W-1:0]   shadow_flat;
  logic                   wr_ready_c;
  logic                   buf_wr, buf_clr, publish;

  banner_shadow_buf #(.N(N), .FILL(FILL)) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (buf_wr),
    .wr_idx   (count),
    .wr_digit (bus.wr_data),
    .clr      (buf_clr),
    .flat     (shadow_flat)
  );

  // A pending clear or commit blocks the write so the three never collide on one edge.
  assign wr_ready_c = (state != ST_FULL) && (state != ST_SWAP) && !bus.clear && !bus.commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_EMPTY;
      count  <= '0;
      data_q <= {N{FILL}};
    end else begin
      state <= state_n;
      count <= count_n;
      if (publish) data_q <= shadow_flat;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    buf_wr  = 1'b0;
    buf_clr = 1'b0;
    publish = 1'b0;
    case (state)
      ST_SWAP: begin
        state_n = ST_EMPTY;
        count_n = '0;
        buf_clr = 1'b1;
        publish = 1'b1;
      end
      default: begin
        if (bus.clear) begin
          state_n = ST_EMPTY;
          count_n = '0;
          buf_clr = 1'b1;
        end else if (bus.commit) begin
          state_n = ST_SWAP;
        end else if (bus.wr_valid && wr_ready_c) begin
          buf_wr  = 1'b1;
          count_n = COUNT_W'(count + COUNT_W'(1));
          if (count_n == COUNT_W'(N)) begin
`ifdef BANNER_AUTOCOMMIT_EN
            state_n = ST_SWAP;
`else
            state_n = ST_FULL;
`endif
          end else begin
            state_n = ST_FILL;
          end
        end
      end
    endcase
  end

  assign bus.wr_ready = wr_ready_c;
  assign bus.data     = data_q;
  assign bus.count    = count;
  assign bus.full     = (state == ST_FULL);
  assign bus.busy     = (state == ST_SWAP);

endmodule
